// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle for the N-channel registered mux.
// Producers and the consumer drive the master side; the mux takes the slave side.
interface mux_nx1_rr_if #(
   parameter int NCH = 8,
   parameter int W   = 8
);
   localparam int SELW = $clog2(NCH);

   logic              mode;
   logic [SELW-1:0]   sel;
   logic [NCH-1:0]    ch_en;
   logic [NCH*W-1:0]  din;
   logic [NCH-1:0]    din_valid;
   logic [NCH-1:0]    din_ready;
   logic [W-1:0]      dout;
   logic [SELW-1:0]   dout_ch;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      output mode, sel, ch_en,
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_ch, dout_valid
   );

   modport slave (
      input  mode, sel, ch_en,
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_ch, dout_valid
   );
endinterface

// File: rtl/mux_nx1_rr.sv
// N-channel W-bit registered mux with manual select or round-robin scan.
// A single output register; one word per clock when downstream keeps up.
module mux_nx1_rr #(
   parameter int NCH = 8,
   parameter int W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_nx1_rr_if.slave  bus
);
   localparam int SELW = $clog2(NCH);

   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] gnt;
   logic [SELW-1:0] idx;
   logic            gnt_vld;
   logic            can_load;
   logic            xfer;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      if (!bus.mode) begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.sel == SELW'(i) && bus.din_valid[i]) begin
               gnt     = SELW'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         // Walk farthest-first so the nearest candidate after rr_ptr wins.
         for (int k = NCH; k >= 1; k--) begin
            idx = SELW'((int'(rr_ptr) + k) % NCH);
            if (bus.ch_en[idx] && bus.din_valid[idx]) begin
               gnt     = idx;
               gnt_vld = 1'b1;
            end
         end
      end
   end

   assign can_load = !bus.dout_valid || bus.dout_ready;
   assign xfer     = gnt_vld && can_load;

   always_comb begin
      bus.din_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         bus.din_ready[i] = rst_n && xfer && (gnt == SELW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dout       <= '0;
         bus.dout_ch    <= '0;
         bus.dout_valid <= 1'b0;
         rr_ptr         <= SELW'(NCH - 1);
      end else if (xfer) begin
         bus.dout       <= bus.din[gnt*W +: W];
         bus.dout_ch    <= gnt;
         bus.dout_valid <= 1'b1;
         if (bus.mode) begin
            rr_ptr <= gnt;
         end
      end else if (bus.dout_ready) begin
         bus.dout_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed and random checks of mux_nx1_rr against a cycle-level
// reference model built from integer channel arithmetic.
module tb_mux_nx1_rr;
   localparam int NCH = 8;
   localparam int W   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mux_nx1_rr_if #(.NCH(NCH), .W(W)) bus ();

   mux_nx1_rr #(.NCH(NCH), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int           m_ptr;
   bit           m_valid;
   logic [W-1:0] m_dout;
   int           m_ch;

   int t2_seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
   int t3_seq [5]  = '{2, 5, 7, 2, 5};
   int t3b_seq [3] = '{7, 2, 7};

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Next channel that the rules allow, or -1 when nothing may transfer.
   function automatic int model_grant();
      if (!bus.mode) begin
         if (int'(bus.sel) < NCH && bus.din_valid[bus.sel])
            return int'(bus.sel);
         return -1;
      end
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (bus.ch_en[c] && bus.din_valid[c])
            return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr   = NCH - 1;
      m_valid = 1'b0;
      m_dout  = '0;
      m_ch    = 0;
   endtask

   task automatic step(input string tag);
      int             g;
      bit             can;
      logic [NCH-1:0] er;
      #1;
      g   = model_grant();
      can = !m_valid || bus.dout_ready;
      er  = '0;
      if (g >= 0 && can)
         er[g] = 1'b1;
      chk({tag, ".rdy"}, 64'(bus.din_ready), 64'(er));
      @(posedge clk);
      if (g >= 0 && can) begin
         m_dout  = bus.din[g*W +: W];
         m_ch    = g;
         m_valid = 1'b1;
         if (bus.mode)
            m_ptr = g;
      end else if (bus.dout_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk({tag, ".vld"}, 64'(bus.dout_valid), 64'(m_valid));
      chk({tag, ".dout"}, 64'(bus.dout), 64'(m_dout));
      chk({tag, ".ch"}, 64'(bus.dout_ch), 64'(m_ch));
   endtask

   initial begin
      bus.mode       = 1'b0;
      bus.sel        = '0;
      bus.ch_en      = '0;
      bus.din        = '0;
      bus.din_valid  = '1;
      bus.dout_ready = 1'b1;
      model_reset();

      // Reset values, with a would-be grant present
      #3;
      chk("rst_vld", 64'(bus.dout_valid), 64'(0));
      chk("rst_dout", 64'(bus.dout), 64'(0));
      chk("rst_ch", 64'(bus.dout_ch), 64'(0));
      chk("rst_rdy", 64'(bus.din_ready), 64'(0));
      bus.din_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: manual select sweep
      for (int i = 0; i < NCH; i++)
         bus.din[i*W +: W] = W'(8'h10 + i);
      bus.din_valid = '1;
      for (int i = 0; i < NCH; i++) begin
         bus.sel = 3'(i);
         step("t1");
         chk("t1_dout", 64'(bus.dout), 64'(8'h10 + i));
         chk("t1_ch", 64'(bus.dout_ch), 64'(i));
      end

      // 2: scan from reset, all enabled
      bus.din_valid = '0;
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      bus.mode      = 1'b1;
      bus.ch_en     = '1;
      bus.din_valid = '1;
      for (int i = 0; i < 10; i++) begin
         step("t2");
         chk("t2_seq", 64'(bus.dout_ch), 64'(t2_seq[i]));
         chk("t2_vld", 64'(bus.dout_valid), 64'(1));
      end

      // 3: sparse enables, then one channel goes idle
      bus.ch_en = 8'b1010_0100;
      for (int i = 0; i < 5; i++) begin
         step("t3");
         chk("t3_seq", 64'(bus.dout_ch), 64'(t3_seq[i]));
      end
      bus.din_valid[5] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("t3b");
         chk("t3b_seq", 64'(bus.dout_ch), 64'(t3b_seq[i]));
      end

      // 4: backpressure holds the word, then drain+load together
      bus.mode      = 1'b0;
      bus.din_valid = '1;
      bus.sel       = 3'd1;
      step("t4_load");
      bus.dout_ready = 1'b0;
      bus.sel        = 3'd4;
      for (int i = 0; i < 3; i++) begin
         step("t4_hold");
         chk("t4_dout", 64'(bus.dout), 64'(8'h11));
         chk("t4_ch", 64'(bus.dout_ch), 64'(1));
         chk("t4_rdy", 64'(bus.din_ready), 64'(0));
      end
      bus.dout_ready = 1'b1;
      step("t4_go");
      chk("t4_go_dout", 64'(bus.dout), 64'(8'h14));
      chk("t4_go_ch", 64'(bus.dout_ch), 64'(4));

      // 5: selected channel has no data
      bus.sel       = 3'd3;
      bus.din_valid = 8'hF7;
      step("t5");
      chk("t5_vld", 64'(bus.dout_valid), 64'(0));

      // 6: asynchronous reset mid-stream
      bus.mode      = 1'b1;
      bus.ch_en     = '1;
      bus.din_valid = '1;
      for (int i = 0; i < 3; i++)
         step("t6_run");
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_vld", 64'(bus.dout_valid), 64'(0));
      chk("t6_dout", 64'(bus.dout), 64'(0));
      chk("t6_rdy", 64'(bus.din_ready), 64'(0));
      #2 rst_n = 1'b1;
      step("t6_first");
      chk("t6_first_ch", 64'(bus.dout_ch), 64'(0));

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         bus.mode       = 1'($urandom_range(0, 1));
         bus.sel        = 3'($urandom_range(0, NCH - 1));
         bus.ch_en      = 8'($urandom);
         bus.din_valid  = 8'($urandom);
         bus.din        = {$urandom, $urandom};
         bus.dout_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
